// File: rtl/wallace_mult_pipe.sv
// rtl/wallace_mult_pipe.sv - pipelined Wallace-tree multiplier, unsigned or Baugh-Wooley signed per transaction
module wallace_mult_pipe #(
    parameter int WIDTH       = 8,
    parameter int PIPE_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod
);

    localparam int PW   = 2 * WIDTH;
    localparam int ROWS = WIDTH + 1;

    typedef logic [ROWS-1:0][PW-1:0] rows_t;

    function automatic int rows_after(input int layers);
        int r;
        r = ROWS;
        for (int i = 0; i < layers; i++) r = 2 * (r / 3) + r % 3;
        return r;
    endfunction

    function automatic int count_layers();
        int r;
        int n;
        r = ROWS;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (r > 2) begin
                r = 2 * (r / 3) + r % 3;
                n++;
            end
        end
        return n;
    endfunction

    localparam int LAYERS = count_layers();

    // Layer l lives in stage floor(l*S/L): layers spread evenly, CPA stays in the last stage.
    function automatic int stage_of(input int l);
        return (l * PIPE_STAGES) / LAYERS;
    endfunction

    function automatic int first_layer(input int s);
        int res;
        res = -1;
        for (int l = LAYERS - 1; l >= 0; l--) if (stage_of(l) == s) res = l;
        return res;
    endfunction

    function automatic int last_layer(input int s);
        int res;
        res = -1;
        for (int l = 0; l < LAYERS; l++) if (stage_of(l) == s) res = l;
        return res;
    endfunction

    // One Wallace layer: every complete triple of rows goes through 3:2 counters, leftovers pass
    // straight down. Columns holding only two live bits collapse to half adders.
    function automatic rows_t csa_layer(input rows_t x, input int n);
        rows_t y;
        int    g;
        y = '0;
        g = n / 3;
        for (int k = 0; k < ROWS / 3; k++) begin
            if (k < g) begin
                y[2*k]   = x[3*k] ^ x[3*k+1] ^ x[3*k+2];
                y[2*k+1] = ((x[3*k] & x[3*k+1]) | (x[3*k] & x[3*k+2]) | (x[3*k+1] & x[3*k+2])) << 1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (k < n % 3) y[2*g+k] = x[3*g+k];
        end
        return y;
    endfunction

    rows_t                  pp;
    logic [PIPE_STAGES-1:0] vld;
    logic [PW-1:0]          prod_q;
    logic                   advance;

    // Baugh-Wooley: invert the terms with exactly one sign bit, add 2^W + 2^(2W-1).
    always_comb begin
        pp = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp[i][i+j] = (in_a[j] & in_b[i]) ^
                             (in_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
        if (in_signed) begin
            pp[WIDTH][WIDTH] = 1'b1;
            pp[WIDTH][PW-1]  = 1'b1;
        end
    end

    for (genvar l = 0; l < LAYERS; l++) begin : g_layer
        localparam int SL = stage_of(l);
        rows_t din;
        rows_t dout;
        if (l == first_layer(SL)) begin : g_head
            if (SL == 0) begin : g_first
                assign din = pp;
            end else begin : g_from_reg
                assign din = g_stage[SL-1].g_reg.bank_q;
            end
        end else begin : g_chain
            assign din = g_layer[l-1].dout;
        end
        assign dout = csa_layer(din, rows_after(l));
    end

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        localparam int LL = last_layer(s);
        rows_t dout;
        if (LL >= 0) begin : g_tail
            assign dout = g_layer[LL].dout;
        end else if (s == 0) begin : g_pass_pp
            assign dout = pp;
        end else begin : g_pass_reg
            assign dout = g_stage[s-1].g_reg.bank_q;
        end

        if (s < PIPE_STAGES - 1) begin : g_reg
            rows_t bank_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    bank_q <= '0;
                end else if (advance) begin
                    bank_q <= dout;
                end
            end
        end else begin : g_cpa
            always_ff @(posedge clk) begin
                if (rst) begin
                    prod_q <= '0;
                end else if (advance) begin
                    prod_q <= dout[0] + dout[1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (advance) begin
            vld <= (vld << 1) | PIPE_STAGES'(in_valid);
        end
    end

    assign out_valid = vld[PIPE_STAGES-1];
    assign advance   = !out_valid | out_ready;
    assign in_ready  = advance | rst;
    // Bubble stages may carry stale data; mask it at the port.
    assign out_prod  = out_valid ? prod_q : '0;

endmodule
